mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter MEM_LATENCY, default 4, meaning memory access cycles (legal 1..15).
REQ-003 SHALL have ports: clk  in  1  single clock, all state rising-edge; rst_b  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: halted  in  1  core halted, blocks new grants.
REQ-005 SHALL have ports: i_req  in  1  fetch request; i_addr  in  XLEN  fetch address; i_ready  out  1  fetch done pulse; i_rdata  out  XLEN  fetched word.
REQ-006 SHALL have ports: d_req  in  1  data request; d_we  in  1  data write; d_addr  in  XLEN  data address; d_wdata  in  8x[0:3]  write bytes; d_ready  out  1  data done pulse; d_rdata  out  8x[0:3]  read bytes.
REQ-007 SHALL have ports: mem_addr  out  XLEN  memory address; mem_data_in  out  8x[0:3]  write bytes; mem_write_en  out  1  write strobe; mem_data_out  in  8x[0:3]  read bytes.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-009 IDLE: if (i_req|d_req) and !halted, latch winner's addr/we/wdata, go ACCESS; else stay.
REQ-010 Arbitration SHALL be round-robin: both pending -> grant the requester not granted last; last_grant resets to fetch (so data wins first tie).
REQ-011 Single pending request SHALL be granted regardless of last_grant.
REQ-012 ACCESS SHALL last exactly MEM_LATENCY cycles, counted by a 4-bit down-counter loaded with MEM_LATENCY-1.
REQ-013 During ACCESS, mem_addr/mem_data_in SHALL equal latched values; outside ACCESS mem_addr=0, mem_data_in=0.
REQ-014 mem_write_en SHALL be 1 only in the final ACCESS cycle of a granted write; exactly one pulse per write.
REQ-015 On final ACCESS cycle of a read, mem_data_out SHALL be registered into the winner's rdata register; go RESP.
REQ-016 RESP: winner's ready=1 for exactly one cycle, rdata valid that cycle; next state IDLE.
REQ-017 Latency: request sampled in IDLE at cycle t -> ready at cycle t+MEM_LATENCY+1; next grant sampled no earlier than t+MEM_LATENCY+2.
REQ-018 Requesters SHALL hold req/addr/wdata stable until ready; changes after latch are ignored.
REQ-019 i_rdata (as XLEN word, byte 0 = bits 31:24) and d_rdata SHALL hold last read value until overwritten; write grants do not modify d_rdata.
REQ-020 halted asserted during ACCESS/RESP SHALL NOT abort the transaction; only IDLE grants blocked.
REQ-021 i_ready and d_ready SHALL never be 1 in the same cycle.
REQ-022 i_req with d_we irrelevant; fetch grants are always reads.

Reset
REQ-023 rst_b low SHALL immediately force state IDLE, counter 0, last_grant=fetch, i_ready=d_ready=0, mem_write_en=0, mem_addr=0, mem_data_in=0, i_rdata=0, d_rdata=0.
REQ-024 Reset mid-ACCESS SHALL abort; a write whose strobe cycle was not reached SHALL never be strobed.
REQ-025 First grant SHALL be possible on the first rising edge after rst_b deasserts.

Structure
REQ-026 State enum (IDLE/ACCESS/RESP) and grant enum (GNT_I/GNT_D) SHALL live in package mem_arb_pkg.
REQ-027 Round-robin pick logic SHALL be sub-module arb_rr (inputs i_req, d_req, last_grant; output grant, valid).

Verification
REQ-028 Fetch only, i_addr=0x100, mem word 0x8C010004, latency 4: i_ready at t+5, i_rdata=0x8C010004, no write strobe.
REQ-029 Data write d_addr=0x200, wdata {0xDE,0xAD,0xBE,0xEF}: mem_write_en single pulse at t+4 with mem_addr=0x200; read-back returns same bytes.
REQ-030 i_req and d_req held high together for 4 transactions: grant order D,I,D,I; ready pulses never overlap.
REQ-031 halted=1 with i_req=1 in IDLE: no grant for 10 cycles; halted raised mid-ACCESS: transaction completes, ready pulses.
REQ-032 Write granted, rst_b pulsed low at ACCESS cycle 2: mem_write_en never asserts, all outputs at reset values.
REQ-033 MEM_LATENCY=1: read ready at t+2, back-to-back request granted at t+3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port (fetch/data) memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   localparam int CNT_W = 4;

   // Down-counter preload so that ACCESS spans exactly lat cycles.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr.sv
// Round-robin pick between fetch and data requesters; a lone requester always wins.
module arb_rr
   import mem_arb_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
   input  grant_t last_grant,
   output grant_t grant,
   output logic   valid
);

   // Winner selection: on a tie, grant whoever was not granted last.
   always_comb begin
      valid = i_req | d_req;
      grant = GNT_I;
      if (i_req && d_req) begin
         if (last_grant == GNT_I) begin
            grant = GNT_D;
         end else begin
            grant = GNT_I;
         end
      end else if (d_req) begin
         grant = GNT_D;
      end else begin
         grant = GNT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_LATENCY = 4
)(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              halted,
   input  logic              i_req,
   input  logic [XLEN-1:0]   i_addr,
   output logic              i_ready,
   output logic [XLEN-1:0]   i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [0:3][7:0]   d_wdata,
   output logic              d_ready,
   output logic [0:3][7:0]   d_rdata,
   output logic [XLEN-1:0]   mem_addr,
   output logic [0:3][7:0]   mem_data_in,
   output logic              mem_write_en,
   input  logic [0:3][7:0]   mem_data_out
);

   localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LATENCY);

   state_t            state_r, state_n;
   logic [CNT_W-1:0]  cnt_r, cnt_n;
   grant_t            gnt_r, gnt_n;
   grant_t            last_r, last_n;
   logic              we_r, we_n;
   logic [XLEN-1:0]   addr_r, addr_n;
   logic [0:3][7:0]   wdata_r, wdata_n;
   logic              wen_r, wen_n;
   logic              i_rdy_r, i_rdy_n;
   logic              d_rdy_r, d_rdy_n;
   logic [XLEN-1:0]   i_rdata_r, i_rdata_n;
   logic [0:3][7:0]   d_rdata_r, d_rdata_n;
   grant_t            arb_grant_s;
   logic              arb_valid_s;

   arb_rr u_arb (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_grant (last_r),
      .grant      (arb_grant_s),
      .valid      (arb_valid_s)
   );

   // State and output registers; memory-side outputs are zero whenever not in ACCESS.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         gnt_r     <= GNT_I;
         last_r    <= GNT_I;
         we_r      <= 1'b0;
         addr_r    <= '0;
         wdata_r   <= '0;
         wen_r     <= 1'b0;
         i_rdy_r   <= 1'b0;
         d_rdy_r   <= 1'b0;
         i_rdata_r <= '0;
         d_rdata_r <= '0;
      end else begin
         state_r   <= state_n;
         cnt_r     <= cnt_n;
         gnt_r     <= gnt_n;
         last_r    <= last_n;
         we_r      <= we_n;
         addr_r    <= addr_n;
         wdata_r   <= wdata_n;
         wen_r     <= wen_n;
         i_rdy_r   <= i_rdy_n;
         d_rdy_r   <= d_rdy_n;
         i_rdata_r <= i_rdata_n;
         d_rdata_r <= d_rdata_n;
      end
   end

   // Next-state logic; the write strobe is scheduled one edge ahead so it lands in the last ACCESS cycle.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      gnt_n     = gnt_r;
      last_n    = last_r;
      we_n      = we_r;
      addr_n    = addr_r;
      wdata_n   = wdata_r;
      wen_n     = 1'b0;
      i_rdy_n   = 1'b0;
      d_rdy_n   = 1'b0;
      i_rdata_n = i_rdata_r;
      d_rdata_n = d_rdata_r;
      case (state_r)
         IDLE: begin
            if (arb_valid_s && !halted) begin
               state_n = ACCESS;
               cnt_n   = LAT_LOAD;
               gnt_n   = arb_grant_s;
               last_n  = arb_grant_s;
               if (arb_grant_s == GNT_D) begin
                  we_n    = d_we;
                  addr_n  = d_addr;
                  wdata_n = d_wdata;
               end else begin
                  we_n    = 1'b0;
                  addr_n  = i_addr;
                  wdata_n = '0;
               end
               wen_n = (arb_grant_s == GNT_D) && d_we && (LAT_LOAD == 4'd0);
            end else begin
               state_n = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == 4'd0) begin
               state_n = RESP;
               addr_n  = '0;
               wdata_n = '0;
               we_n    = 1'b0;
               if (gnt_r == GNT_I) begin
                  i_rdy_n   = 1'b1;
                  i_rdata_n = XLEN'(mem_data_out);
               end else begin
                  d_rdy_n = 1'b1;
                  if (!we_r) begin
                     d_rdata_n = mem_data_out;
                  end else begin
                     d_rdata_n = d_rdata_r;
                  end
               end
            end else begin
               cnt_n = cnt_r - 4'd1;
               wen_n = we_r && (cnt_r == 4'd1);
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign i_ready      = i_rdy_r;
   assign d_ready      = d_rdy_r;
   assign i_rdata      = i_rdata_r;
   assign d_rdata      = d_rdata_r;
   assign mem_addr     = addr_r;
   assign mem_data_in  = wdata_r;
   assign mem_write_en = wen_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-4 instance plus a latency-1 instance.
module tb_mem_arbiter;

   logic             clk;
   logic             rst_b;
   logic             halted;
   logic             i_req, i_req1;
   logic [31:0]      i_addr;
   logic             i_ready, i_ready1;
   logic [31:0]      i_rdata, i_rdata1;
   logic             d_req, d_we;
   logic [31:0]      d_addr;
   logic [0:3][7:0]  d_wdata;
   logic             d_ready, d_ready1;
   logic [0:3][7:0]  d_rdata, d_rdata1;
   logic [31:0]      mem_addr, mem_addr1;
   logic [0:3][7:0]  mem_data_in, mem_data_in1;
   logic             mem_write_en, mem_write_en1;
   logic [0:3][7:0]  mem_data_out, mem_data_out1;

   int n_total = 0;
   int n_bad   = 0;
   int overlap_cnt = 0;

   mem_arbiter #(.XLEN(32), .MEM_LATENCY(4)) dut (
      .clk(clk), .rst_b(rst_b), .halted(halted),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
   );

   mem_arbiter #(.XLEN(32), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst_b(rst_b), .halted(1'b0),
      .i_req(i_req1), .i_addr(i_addr), .i_ready(i_ready1), .i_rdata(i_rdata1),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ready(d_ready1), .d_rdata(d_rdata1),
      .mem_addr(mem_addr1), .mem_data_in(mem_data_in1),
      .mem_write_en(mem_write_en1), .mem_data_out(mem_data_out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: preloaded word at 0x100, writes tracked per word.
   logic          mem_clr_n;
   logic [255:0]  wr_valid;
   logic [31:0]   wr_data [0:255];

   function automatic logic [31:0] base_word(input logic [7:0] idx);
      if (idx == 8'd64) return 32'h8C01_0004;
      else return 32'h0;
   endfunction

   always @(posedge clk or negedge mem_clr_n) begin
      if (!mem_clr_n) begin
         wr_valid <= '0;
      end else if (mem_write_en) begin
         wr_valid[mem_addr[9:2]] <= 1'b1;
         wr_data[mem_addr[9:2]]  <= mem_data_in;
      end
   end

   always_comb begin
      mem_data_out  = wr_valid[mem_addr[9:2]] ? wr_data[mem_addr[9:2]] : base_word(mem_addr[9:2]);
      mem_data_out1 = wr_valid[mem_addr1[9:2]] ? wr_data[mem_addr1[9:2]] : base_word(mem_addr1[9:2]);
   end

   always @(negedge clk) begin
      if ((i_ready && d_ready) || (i_ready1 && d_ready1)) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the chosen ready; reports cycle index and any write strobes seen.
   task automatic wait_ready(input bit want_d, output int cyc, output int wcnt,
                             output int wcyc, output logic [31:0] waddr, output logic [31:0] wdat);
      cyc = -1; wcnt = 0; wcyc = -1; waddr = 32'h0; wdat = 32'h0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (mem_write_en) begin
            wcnt++; wcyc = k; waddr = mem_addr; wdat = mem_data_in;
         end
         if (want_d ? d_ready : i_ready) begin
            cyc = k;
            break;
         end
      end
   endtask

   int          cyc, wcnt, wcyc, who, first1, second1, grants;
   logic [31:0] waddr, wdat;
   int          exp_order [4] = '{1, 0, 1, 0};

   initial begin
      mem_clr_n = 1'b0; rst_b = 1'b0; halted = 1'b0;
      i_req = 1'b0; i_req1 = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      #2 mem_clr_n = 1'b1;
      repeat (3) tick();
      check_val("rst_i_ready", i_ready, 0);
      check_val("rst_d_ready", d_ready, 0);
      check_val("rst_wen", mem_write_en, 0);
      check_val("rst_addr", mem_addr, 0);
      check_val("rst_wdata", mem_data_in, 0);
      check_val("rst_i_rdata", i_rdata, 0);
      check_val("rst_d_rdata", d_rdata, 0);

      // Fetch right after reset release
      rst_b = 1'b1; i_req = 1'b1; i_addr = 32'h100;
      wait_ready(1'b0, cyc, wcnt, wcyc, waddr, wdat);
      check_val("fetch_lat", cyc, 5);
      check_val("fetch_data", i_rdata, 32'h8C01_0004);
      check_val("fetch_nowen", wcnt, 0);
      i_req = 1'b0;
      tick();
      check_val("fetch_pulse1", i_ready, 0);

      // Data write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
      wait_ready(1'b1, cyc, wcnt, wcyc, waddr, wdat);
      check_val("wr_lat", cyc, 5);
      check_val("wr_wen_cnt", wcnt, 1);
      check_val("wr_wen_cyc", wcyc, 4);
      check_val("wr_wen_addr", waddr, 32'h200);
      check_val("wr_wen_data", wdat, 32'hDEAD_BEEF);
      check_val("wr_rdata_kept", d_rdata, 0);
      d_req = 1'b0; d_we = 1'b0;
      tick();

      // Read-back; address/data changed after the grant must be ignored
      d_req = 1'b1; d_we = 1'b0;
      tick();
      d_addr = 32'h100; d_wdata = 32'h0;
      wait_ready(1'b1, cyc, wcnt, wcyc, waddr, wdat);
      check_val("rd_lat", cyc, 4);
      check_val("rd_data", d_rdata, 32'hDEAD_BEEF);
      check_val("rd_nowen", wcnt, 0);
      d_req = 1'b0;
      tick();

      // Round robin from reset: data wins first tie
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      for (int n = 0; n < 4; n++) begin
         who = -1;
         for (int k = 0; k < 20; k++) begin
            tick();
            if (i_ready || d_ready) begin
               who = d_ready ? 1 : 0;
               break;
            end
         end
         check_val($sformatf("rr_order_%0d", n), who, exp_order[n]);
      end
      i_req = 1'b0; d_req = 1'b0;
      check_val("rr_i_rdata", i_rdata, 32'h8C01_0004);
      check_val("rr_d_rdata", d_rdata, 32'hDEAD_BEEF);
      tick();

      // Halted blocks grants in IDLE only
      halted = 1'b1; i_req = 1'b1; i_addr = 32'h100;
      grants = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (mem_addr != 32'h0 || i_ready) grants++;
      end
      check_val("halt_nogrant", grants, 0);
      halted = 1'b0;
      tick();
      halted = 1'b1;
      wait_ready(1'b0, cyc, wcnt, wcyc, waddr, wdat);
      check_val("halt_midaccess_lat", cyc, 4);
      i_req = 1'b0;
      tick();
      halted = 1'b0;

      // Reset during ACCESS cycle 2 of a write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1122_3344;
      tick();
      tick();
      check_val("abort_in_access", mem_addr, 32'h300);
      rst_b = 1'b0;
      #1;
      check_val("abort_wen", mem_write_en, 0);
      check_val("abort_addr", mem_addr, 0);
      check_val("abort_wdata", mem_data_in, 0);
      check_val("abort_i_rdata", i_rdata, 0);
      check_val("abort_d_rdata", d_rdata, 0);
      check_val("abort_ready", {i_ready, d_ready}, 0);
      d_req = 1'b0; d_we = 1'b0;
      repeat (3) tick();
      rst_b = 1'b1;
      repeat (6) tick();
      check_val("abort_never_written", wr_valid[192], 0);

      // Latency 1: ready at t+2, back-to-back grant gives next ready at t+5
      i_req1 = 1'b1; i_addr = 32'h100;
      first1 = -1; second1 = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (i_ready1) begin
            if (first1 < 0) first1 = k;
            else begin
               second1 = k;
               break;
            end
         end
      end
      i_req1 = 1'b0;
      check_val("lat1_first", first1, 2);
      check_val("lat1_second", second1, 5);
      check_val("lat1_data", i_rdata1, 32'h8C01_0004);
      tick();

      check_val("ready_overlap", overlap_cnt, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
